// File: rtl/pipe_pkg.sv
// Shared pipeline constants: data/index widths, write-back source encodings, zero-register index.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'b00,
        WB_SEL_MEM = 2'b01,
        WB_SEL_NPC = 2'b10,
        WB_SEL_RSV = 2'b11
    } wb_sel_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_2r1w.sv
// Two combinational read ports, one write port committed on posedge; r0 hardwired to zero.
// Async active-low clear of all storage; optional same-cycle write-through bypass under WB_BYPASS_EN.
module regfile_2r1w #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int ADDR_W = pipe_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);
    import pipe_pkg::*;

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [NREG];
    logic              wr_ok;

    assign wr_ok = we && (waddr != ADDR_W'(REG_ZERO));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef WB_BYPASS_EN
    // Bypass must not leak write data while reset holds the array cleared.
    always_comb begin
        rdata_a = mem[raddr_a];
        rdata_b = mem[raddr_b];
        if (wr_ok && reset && (raddr_a == waddr)) rdata_a = wdata;
        if (wr_ok && reset && (raddr_b == waddr)) rdata_b = wdata;
        if (raddr_a == ADDR_W'(REG_ZERO)) rdata_a = '0;
        if (raddr_b == ADDR_W'(REG_ZERO)) rdata_b = '0;
    end
`else
    always_comb begin
        rdata_a = mem[raddr_a];
        rdata_b = mem[raddr_b];
        if (raddr_a == ADDR_W'(REG_ZERO)) rdata_a = '0;
        if (raddr_b == ADDR_W'(REG_ZERO)) rdata_b = '0;
    end
`endif

endmodule

// File: rtl/wb_regfile.sv
// Write-back select + 32x32 register file; commit 1 edge after wb_en, reads combinational, no backpressure.
// Define WB_BYPASS_EN to make a same-cycle write visible on the read ports.
module wb_regfile #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int ADDR_W = pipe_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] c_MEM_WB,
    input  logic [DATA_W-1:0] npc_MEM_WB,
    input  logic [DATA_W-1:0] data_out_MEM_WB,
    input  logic [ADDR_W-1:0] num_write_MEM_WB,
    input  logic              reg_write_MEM_WB,
    input  logic [1:0]        s_data_write_MEM_WB,
    input  logic [ADDR_W-1:0] num_a,
    input  logic [ADDR_W-1:0] num_b,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] data_write,
    output logic              wb_en,
    output logic [31:0]       commit_count
);
    import pipe_pkg::*;

    always_comb begin
        data_write = '0;
        case (s_data_write_MEM_WB)
            WB_SEL_ALU: data_write = c_MEM_WB;
            WB_SEL_MEM: data_write = data_out_MEM_WB;
            WB_SEL_NPC: data_write = npc_MEM_WB;
            default:    data_write = '0;
        endcase
    end

    // Reserved select and r0 targets never commit, so they never count either.
    assign wb_en = reg_write_MEM_WB
                && (num_write_MEM_WB != ADDR_W'(REG_ZERO))
                && (s_data_write_MEM_WB != WB_SEL_RSV);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            commit_count <= '0;
        end else if (wb_en) begin
            commit_count <= commit_count + 32'd1;
        end
    end

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rf (
        .clock   (clock),
        .reset   (reset),
        .we      (wb_en),
        .waddr   (num_write_MEM_WB),
        .wdata   (data_write),
        .raddr_a (num_a),
        .raddr_b (num_b),
        .rdata_a (a),
        .rdata_b (b)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed plan plus randomized traffic, checked each negedge against an array model.
module tb_wb_regfile;

    logic        clock;
    logic        reset;
    logic [31:0] c_MEM_WB;
    logic [31:0] npc_MEM_WB;
    logic [31:0] data_out_MEM_WB;
    logic [4:0]  num_write_MEM_WB;
    logic        reg_write_MEM_WB;
    logic [1:0]  s_data_write_MEM_WB;
    logic [4:0]  num_a;
    logic [4:0]  num_b;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data_write;
    logic        wb_en;
    logic [31:0] commit_count;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    logic [31:0] mregs [32];
    logic [31:0] mcount;

    wb_regfile dut (
        .clock               (clock),
        .reset               (reset),
        .c_MEM_WB            (c_MEM_WB),
        .npc_MEM_WB          (npc_MEM_WB),
        .data_out_MEM_WB     (data_out_MEM_WB),
        .num_write_MEM_WB    (num_write_MEM_WB),
        .reg_write_MEM_WB    (reg_write_MEM_WB),
        .s_data_write_MEM_WB (s_data_write_MEM_WB),
        .num_a               (num_a),
        .num_b               (num_b),
        .a                   (a),
        .b                   (b),
        .data_write          (data_write),
        .wb_en               (wb_en),
        .commit_count        (commit_count)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the stage must produce, from the selection/commit rules.
    function automatic logic [31:0] exp_dw();
        case (s_data_write_MEM_WB)
            2'd0:    return c_MEM_WB;
            2'd1:    return data_out_MEM_WB;
            2'd2:    return npc_MEM_WB;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic exp_wb_en();
        return reg_write_MEM_WB && num_write_MEM_WB != 0 && s_data_write_MEM_WB != 2'd3;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] n);
        if (n == 0 || !reset) return 32'd0;
`ifdef WB_BYPASS_EN
        if (exp_wb_en() && n == num_write_MEM_WB) return exp_dw();
`endif
        return mregs[n];
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
            mcount = 32'd0;
        end else if (exp_wb_en()) begin
            mregs[num_write_MEM_WB] = exp_dw();
            mcount = mcount + 32'd1;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("cyc_a",     a,                   exp_rd(num_a));
            chk("cyc_b",     b,                   exp_rd(num_b));
            chk("cyc_dw",    data_write,          exp_dw());
            chk("cyc_wb_en", {31'd0, wb_en},      {31'd0, exp_wb_en()});
            chk("cyc_count", commit_count,        mcount);
        end
    end

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic [4:0] idx,
                         input logic [31:0] val, input logic we);
        c_MEM_WB            = $urandom;
        data_out_MEM_WB     = $urandom;
        npc_MEM_WB          = $urandom;
        case (sel)
            2'd1:    data_out_MEM_WB = val;
            2'd2:    npc_MEM_WB      = val;
            default: c_MEM_WB        = val;
        endcase
        s_data_write_MEM_WB = sel;
        num_write_MEM_WB    = idx;
        reg_write_MEM_WB    = we;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        mcount = 32'd0;
        reset = 0;
        c_MEM_WB = 0; npc_MEM_WB = 0; data_out_MEM_WB = 0;
        num_write_MEM_WB = 0; reg_write_MEM_WB = 0; s_data_write_MEM_WB = 0;
        num_a = 0; num_b = 0;
        #2;
        chk_en = 1;
        chk("rst_count", commit_count, 32'd0);
        #10 reset = 1;

        // Every index reads zero after reset
        for (int i = 0; i < 32; i++) begin
            next();
            num_a = 5'(i);
            num_b = 5'(31 - i);
            #2;
            chk("init_a", a, 32'd0);
            chk("init_b", b, 32'd0);
        end
        chk("init_count", commit_count, 32'd0);

        // ALU write
        next(); drive(2'd0, 5'd5, 32'h1234_5678, 1'b1);
        next(); reg_write_MEM_WB = 0; num_a = 5; #2;
        chk("alu_a", a, 32'h1234_5678);
        chk("alu_count", commit_count, 32'd1);

        // Load and link writes
        next(); drive(2'd1, 5'd7, 32'hDEAD_BEEF, 1'b1);
        next(); drive(2'd2, 5'd31, 32'h0040_0008, 1'b1);
        next(); reg_write_MEM_WB = 0; num_a = 7; num_b = 31; #2;
        chk("load_r7", a, 32'hDEAD_BEEF);
        chk("link_r31", b, 32'h0040_0008);
        next(); num_a = 8; #2;
        chk("r8_zero", a, 32'd0);
        chk("ld_count", commit_count, 32'd3);

        // Suppressed writes: r0 target and reserved select
        next(); drive(2'd0, 5'd0, 32'hFFFF_FFFF, 1'b1); #2;
        chk("r0_wb_en", {31'd0, wb_en}, 32'd0);
        next(); drive(2'd3, 5'd9, 32'h5555_5555, 1'b1); #2;
        chk("rsv_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rsv_dw", data_write, 32'd0);
        next(); reg_write_MEM_WB = 0; num_a = 0; num_b = 9; #2;
        chk("r0_read", a, 32'd0);
        chk("r9_read", b, 32'd0);
        chk("sup_count", commit_count, 32'd3);

        // Same-cycle read of the write target
        next(); drive(2'd0, 5'd3, 32'h1111_1111, 1'b1);
        next(); drive(2'd0, 5'd3, 32'hA5A5_A5A5, 1'b1); num_a = 3; num_b = 3; #2;
`ifdef WB_BYPASS_EN
        chk("same_a", a, 32'hA5A5_A5A5);
        chk("same_b", b, 32'hA5A5_A5A5);
`else
        chk("same_a", a, 32'h1111_1111);
        chk("same_b", b, 32'h1111_1111);
`endif
        next(); reg_write_MEM_WB = 0; #2;
        chk("after_a", a, 32'hA5A5_A5A5);
        chk("after_b", b, 32'hA5A5_A5A5);
        chk("same_count", commit_count, 32'd5);

        // Async reset mid-operation
        next(); drive(2'd0, 5'd4, 32'h0000_0044, 1'b1);
        next(); drive(2'd1, 5'd5, 32'h0000_0055, 1'b1);
        next(); drive(2'd2, 5'd6, 32'h0000_0066, 1'b1);
        next(); reg_write_MEM_WB = 0; num_a = 4; num_b = 6; #2;
        chk("pre_a", a, 32'h0000_0044);
        chk("pre_b", b, 32'h0000_0066);
        reset = 0;
        #1;
        chk("arst_a", a, 32'd0);
        chk("arst_b", b, 32'd0);
        chk("arst_count", commit_count, 32'd0);
        next(); drive(2'd0, 5'd10, 32'h0000_0077, 1'b1); num_a = 10;
        next(); reg_write_MEM_WB = 0;
        #1 reset = 1;
        #1;
        chk("rst_drop", a, 32'd0);
        chk("rst_drop_cnt", commit_count, 32'd0);
        drive(2'd0, 5'd10, 32'h0BAD_F00D, 1'b1);
        next(); reg_write_MEM_WB = 0; #2;
        chk("first_commit", a, 32'h0BAD_F00D);
        chk("first_count", commit_count, 32'd1);

        // Randomized traffic with occasional async reset pulses
        for (int n = 0; n < 3000; n++) begin
            next();
            drive(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                  $urandom, 1'($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 3) == 0) num_write_MEM_WB = 5'($urandom);
            num_a = ($urandom_range(0, 1) == 0) ? num_write_MEM_WB : 5'($urandom_range(0, 7));
            num_b = 5'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #1 reset = 0;
                #2 reset = 1;
            end
        end

        next();
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
